// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared constants and the BTB entry layout for the fetch unit.
// No ports. Imported by fetch_pc_unit and fetch_btb.
package fetch_pc_unit_pkg;

    localparam int XLEN = 32;
    localparam int REG_RANGE = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Tag and target are held at full XLEN width; narrower tags are
    // zero-extended so the whole field is compared.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
        logic            taken;
    } btb_entry_t;

endpackage

// File: rtl/fetch_btb.sv
// fetch_btb: direct-mapped branch target buffer, combinational lookup on the
// fetch PC, one write per clock.
// Ports: clk_i, rst_i (async, active-high), lookup_pc_i -> hit_o/target_o,
// upd_en_i/upd_pc_i/upd_target_i/upd_taken_i write one entry.
module fetch_btb
    import fetch_pc_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int BTB_ENTRIES = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] lookup_pc_i,
    output logic             hit_o,
    output logic [WIDTH-1:0] target_o,
    input  logic             upd_en_i,
    input  logic [WIDTH-1:0] upd_pc_i,
    input  logic [WIDTH-1:0] upd_target_i,
    input  logic             upd_taken_i
);

    localparam int LOGB = $clog2(BTB_ENTRIES);
    localparam int TAGW = WIDTH - LOGB - 2;

    btb_entry_t mem_q [BTB_ENTRIES];
    btb_entry_t rd_entry;
    btb_entry_t wr_entry_d;

    logic [LOGB-1:0] rd_idx;
    logic [LOGB-1:0] wr_idx;
    logic [TAGW-1:0] rd_tag;
    logic [TAGW-1:0] wr_tag;
    logic            unused_low;

    assign rd_idx = lookup_pc_i[LOGB+1:2];
    assign rd_tag = lookup_pc_i[WIDTH-1:LOGB+2];
    assign wr_idx = upd_pc_i[LOGB+1:2];
    assign wr_tag = upd_pc_i[WIDTH-1:LOGB+2];

    // Word-aligned PCs: the byte offset never selects an entry.
    assign unused_low = ^{lookup_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

    // Lookup reads the registered array, so a same-cycle write to the
    // same index is seen only from the next cycle.
    assign rd_entry = mem_q[rd_idx];
    assign hit_o    = rd_entry.valid
                    && (rd_entry.tag == XLEN'(rd_tag))
                    && rd_entry.taken;
    assign target_o = WIDTH'(rd_entry.target);

    always_comb begin
        wr_entry_d        = '0;
        wr_entry_d.valid  = 1'b1;
        wr_entry_d.tag    = XLEN'(wr_tag);
        wr_entry_d.target = XLEN'({upd_target_i[WIDTH-1:2], 2'b00});
        wr_entry_d.taken  = upd_taken_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (upd_en_i) begin
            mem_q[wr_idx] <= wr_entry_d;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter, next-PC select and IF/ID PC register.
// Ports: clk, reset (async, active-high); stall, pc_sel_EXIF/target_EXIF
// redirect; btb_upd_* train the BTB; pc to imem; pc_IFID, pc_plus4_IFID,
// pred_taken_IFID aligned with imem data. Macro BTB_PRED_EN builds the BTB.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT),
    parameter int               BTB_ENTRIES  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_sel_EXIF,
    input  logic [WIDTH-1:0] target_EXIF,
    input  logic             btb_upd_en,
    input  logic [WIDTH-1:0] btb_upd_pc,
    input  logic [WIDTH-1:0] btb_upd_target,
    input  logic             btb_upd_taken,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_IFID,
    output logic [WIDTH-1:0] pc_plus4_IFID,
    output logic             pred_taken_IFID
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] ifid_pc_q;
    logic [WIDTH-1:0] ifid_pc_d;
    logic [WIDTH-1:0] ifid_pc4_q;
    logic [WIDTH-1:0] ifid_pc4_d;
    logic             ifid_pred_q;
    logic             ifid_pred_d;
    logic             btb_hit;
    logic [WIDTH-1:0] btb_target;
    logic             unused_cfg;

    assign unused_cfg = ^{target_EXIF[1:0], NOP, 32'(REG_RANGE),
                          32'(BTB_ENTRIES)};

`ifdef BTB_PRED_EN
    fetch_btb #(
        .WIDTH       (WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk_i        (clk),
        .rst_i        (reset),
        .lookup_pc_i  (pc_q),
        .hit_o        (btb_hit),
        .target_o     (btb_target),
        .upd_en_i     (btb_upd_en),
        .upd_pc_i     (btb_upd_pc),
        .upd_target_i (btb_upd_target),
        .upd_taken_i  (btb_upd_taken)
    );
`else
    logic unused_upd;

    assign btb_hit    = 1'b0;
    assign btb_target = '0;
    assign unused_upd = ^{btb_upd_en, btb_upd_pc, btb_upd_target,
                          btb_upd_taken};
`endif

    // Wraps modulo 2^WIDTH.
    assign pc_plus4 = pc_q + WIDTH'(4);

    // Redirect outranks stall so a flush never loses a cycle.
    always_comb begin
        pc_d = pc_plus4;
        if (pc_sel_EXIF) begin
            pc_d = {target_EXIF[WIDTH-1:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end else if (btb_hit) begin
            pc_d = btb_target;
        end
    end

    always_comb begin
        ifid_pc_d   = pc_q;
        ifid_pc4_d  = pc_plus4;
        ifid_pred_d = btb_hit;
        if (pc_sel_EXIF) begin
            ifid_pc_d   = '0;
            ifid_pc4_d  = '0;
            ifid_pred_d = 1'b0;
        end else if (stall) begin
            ifid_pc_d   = ifid_pc_q;
            ifid_pc4_d  = ifid_pc4_q;
            ifid_pred_d = ifid_pred_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            ifid_pc_q   <= '0;
            ifid_pc4_q  <= '0;
            ifid_pred_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ifid_pc_q   <= ifid_pc_d;
            ifid_pc4_q  <= ifid_pc4_d;
            ifid_pred_q <= ifid_pred_d;
        end
    end

    assign pc              = pc_q;
    assign pc_IFID         = ifid_pc_q;
    assign pc_plus4_IFID   = ifid_pc4_q;
    assign pred_taken_IFID = ifid_pred_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed checks of fetch_pc_unit
// for either setting of BTB_PRED_EN.
`timescale 1ns/1ps

module tb_fetch_pc_unit;

`ifdef BTB_PRED_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        pc_sel_EXIF;
  logic [31:0] target_EXIF;
  logic        btb_upd_en;
  logic [31:0] btb_upd_pc;
  logic [31:0] btb_upd_target;
  logic        btb_upd_taken;
  logic [31:0] pc;
  logic [31:0] pc_IFID;
  logic [31:0] pc_plus4_IFID;
  logic        pred_taken_IFID;

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  fetch_pc_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .pc_sel_EXIF     (pc_sel_EXIF),
    .target_EXIF     (target_EXIF),
    .btb_upd_en      (btb_upd_en),
    .btb_upd_pc      (btb_upd_pc),
    .btb_upd_target  (btb_upd_target),
    .btb_upd_taken   (btb_upd_taken),
    .pc              (pc),
    .pc_IFID         (pc_IFID),
    .pc_plus4_IFID   (pc_plus4_IFID),
    .pred_taken_IFID (pred_taken_IFID)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       t,
    input logic [31:0] o,
    input logic [31:0] e
  );
    checks++;
    if (o !== e) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             t, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    pc_sel_EXIF = 1'b1;
    target_EXIF = t;
    tick();
    pc_sel_EXIF = 1'b0;
    target_EXIF = '0;
  endtask

  initial begin
    #100000;
    if (!done) begin
      failures++;
      $error("FAIL timeout: stimulus did not finish");
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0;
    pc_sel_EXIF = 1'b0; target_EXIF = '0;
    btb_upd_en = 1'b0; btb_upd_pc = '0;
    btb_upd_target = '0; btb_upd_taken = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ifid", pc_IFID, 32'h0);
    chk("rst_pc4", pc_plus4_IFID, 32'h0);
    chk("rst_pred", 32'(pred_taken_IFID), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("seq0_pc", pc, 32'h0);
    chk("seq0_ifid", pc_IFID, 32'h0);
    tick();
    chk("seq1_pc", pc, 32'h4);
    chk("seq1_ifid", pc_IFID, 32'h0);
    chk("seq1_pc4", pc_plus4_IFID, 32'h4);
    tick();
    chk("seq2_pc", pc, 32'h8);
    chk("seq2_ifid", pc_IFID, 32'h4);

    redirect(32'h1C);
    chk("rd1_pc", pc, 32'h1C);
    tick();
    chk("pre_pc", pc, 32'h20);
    chk("pre_ifid", pc_IFID, 32'h1C);
    stall = 1'b1;
    redirect(32'h103);
    stall = 1'b0;
    chk("rdst_pc", pc, 32'h100);
    chk("rdst_ifid", pc_IFID, 32'h0);
    chk("rdst_pc4", pc_plus4_IFID, 32'h0);
    chk("rdst_pred", 32'(pred_taken_IFID), 32'h0);

    redirect(32'h3C);
    tick();
    chk("st0_pc", pc, 32'h40);
    chk("st0_ifid", pc_IFID, 32'h3C);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_pc", pc, 32'h40);
      chk("st_ifid", pc_IFID, 32'h3C);
      chk("st_pc4", pc_plus4_IFID, 32'h40);
    end
    stall = 1'b0;
    tick();
    chk("st_rel_pc", pc, 32'h44);
    chk("st_rel_ifid", pc_IFID, 32'h40);
    chk("st_rel_pc4", pc_plus4_IFID, 32'h44);

    redirect(32'hFFFF_FFFC);
    chk("wrap0_pc", pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_ifid", pc_IFID, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_IFID, 32'h0);

    btb_upd_en = 1'b1; btb_upd_pc = 32'h10;
    btb_upd_target = 32'h83; btb_upd_taken = 1'b1;
    redirect(32'h0C);
    btb_upd_en = 1'b0;
    chk("bt0_pc", pc, 32'h0C);
    tick();
    chk("bt1_pc", pc, 32'h10);
    tick();
    chk("bt2_pc", pc, BTB ? 32'h80 : 32'h14);
    chk("bt2_ifid", pc_IFID, 32'h10);
    chk("bt2_pred", 32'(pred_taken_IFID), 32'(BTB));
    tick();
    chk("bt3_pc", pc, BTB ? 32'h84 : 32'h18);
    chk("bt3_pred", 32'(pred_taken_IFID), 32'h0);

    btb_upd_en = 1'b1; btb_upd_pc = 32'h10;
    btb_upd_target = 32'h80; btb_upd_taken = 1'b0;
    stall = 1'b1;
    tick();
    stall = 1'b0; btb_upd_en = 1'b0;
    chk("nt_hold_pc", pc, BTB ? 32'h84 : 32'h18);
    redirect(32'h10);
    tick();
    chk("nt_pc", pc, 32'h14);
    chk("nt_pred", 32'(pred_taken_IFID), 32'h0);

    redirect(32'h18);
    btb_upd_en = 1'b1; btb_upd_pc = 32'h18;
    btb_upd_target = 32'h200; btb_upd_taken = 1'b1;
    tick();
    btb_upd_en = 1'b0;
    chk("same_pc", pc, 32'h1C);
    chk("same_ifid", pc_IFID, 32'h18);
    chk("same_pred", 32'(pred_taken_IFID), 32'h0);
    redirect(32'h18);
    tick();
    chk("after_pc", pc, BTB ? 32'h200 : 32'h1C);
    chk("after_pred", 32'(pred_taken_IFID), 32'(BTB));

    #3;
    pc_sel_EXIF = 1'b1; target_EXIF = 32'h500;
    btb_upd_en = 1'b1; btb_upd_pc = 32'h20;
    btb_upd_target = 32'h300; btb_upd_taken = 1'b1;
    reset = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_ifid", pc_IFID, 32'h0);
    chk("arst_pc4", pc_plus4_IFID, 32'h0);
    chk("arst_pred", 32'(pred_taken_IFID), 32'h0);
    tick();
    pc_sel_EXIF = 1'b0; target_EXIF = '0;
    btb_upd_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_pc", pc, 32'h0);
    redirect(32'h18);
    tick();
    chk("post_miss_pc", pc, 32'h1C);
    chk("post_miss_pred", 32'(pred_taken_IFID), 32'h0);
    tick();
    tick();
    chk("post_upd_pc", pc, 32'h24);
    chk("post_upd_pred", 32'(pred_taken_IFID), 32'h0);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: address/data width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter BTB_ENTRIES, default 8: BTB depth, power of two; LOGB = $clog2(BTB_ENTRIES).
REQ-004 Port clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
REQ-005 Control inputs:
- stall  in  1  hold fetch (hazard unit)
- pc_sel_EXIF  in  1  redirect/flush from EX
- target_EXIF  in  WIDTH  redirect address
REQ-006 BTB update inputs:
- btb_upd_en  in  1  write one BTB entry
- btb_upd_pc  in  WIDTH  branch PC
- btb_upd_target  in  WIDTH  resolved target
- btb_upd_taken  in  1  resolved direction
REQ-007 Outputs:
- pc  out  WIDTH  fetch address to instruction memory
- pc_IFID  out  WIDTH  PC aligned with instruction memory output
- pc_plus4_IFID  out  WIDTH  pc_IFID+4
- pred_taken_IFID  out  1  fetched instruction was predicted taken

Function
REQ-008 Next-PC priority, in order: redirect (pc_sel_EXIF=1) -> target_EXIF; stall=1 -> hold pc; BTB hit and taken -> BTB target; otherwise pc+4.
REQ-009 Redirect SHALL win over simultaneous stall; no cycle is lost.
REQ-010 Redirect and BTB targets SHALL be loaded with bits [1:0] forced to 2'b00.
REQ-011 Increment SHALL be modulo 2^WIDTH: 32'hFFFF_FFFC+4 -> 32'h0000_0000.
REQ-012 IF/ID alignment, one-cycle latency:
- on redirect: pc_IFID<=0, pc_plus4_IFID<=0, pred_taken_IFID<=0
- else on stall: all IF/ID outputs hold
- else: pc_IFID<=pc, pc_plus4_IFID<=pc+4, pred_taken_IFID<=current lookup result
REQ-013 BTB lookup SHALL be combinational on pc:
- index = pc[LOGB+1:2]
- tag = pc[WIDTH-1:LOGB+2]
- hit = valid & tag match & stored taken bit
REQ-014 btb_upd_en=1 SHALL write valid=1, tag, target and taken at the index of btb_upd_pc on the clock edge; an update with btb_upd_taken=0 keeps the entry valid with taken=0.
REQ-015 BTB update and lookup to the same index in the same cycle: the lookup uses the old contents; the new contents are visible from the next cycle.
REQ-016 BTB updates SHALL proceed during stall and redirect.

Reset
REQ-017 While reset=1, asynchronously: pc=RESET_VECTOR, pc_IFID=0, pc_plus4_IFID=0, pred_taken_IFID=0, all BTB valid bits=0.
REQ-018 Reset asserted mid-operation SHALL discard pending redirect and update state; the first post-reset fetch is RESET_VECTOR.

Configuration
REQ-019 Macro BTB_PRED_EN:
- defined: BTB built; prediction behaves as REQ-008 and REQ-013 to REQ-016
- undefined: no BTB storage; next PC is target_EXIF, held pc or pc+4 only; pred_taken_IFID is tied to 0; update ports remain and are ignored

Structure
REQ-020 The shared package/include (alongside REG_RANGE and NOP) SHALL hold the RESET_VECTOR default and the BTB entry typedef (valid, tag, target, taken).
REQ-021 BTB storage and lookup SHALL be a sub-module fetch_btb, instantiated only under BTB_PRED_EN.

Verification
REQ-022 Release reset, no stall or redirect for 3 cycles -> pc = 0, 4, 8; pc_IFID = 0, 0, 4.
REQ-023 pc=0x20, assert stall and pc_sel_EXIF together with target_EXIF=0x103 -> next pc=0x100; pc_IFID=0; pred_taken_IFID=0.
REQ-024 stall held for 2 cycles at pc=0x40 -> pc, pc_IFID and pc_plus4_IFID unchanged; released -> pc=0x44.
REQ-025 BTB_PRED_EN defined: update pc 0x10 -> target 0x80, taken=1; later fetch at 0x10 -> next pc=0x80 and pred_taken_IFID=1 in the cycle pc_IFID=0x10. Same-cycle update and lookup -> old result.
REQ-026 BTB_PRED_EN undefined, same stimulus as REQ-025 -> next pc=0x14, pred_taken_IFID=0. Also: pc=0xFFFF_FFFC -> next pc=0.
REQ-027 Assert reset asynchronously mid-cycle with a valid BTB entry -> pc=RESET_VECTOR immediately; the entry misses after release.
